// File: rtl/serial_add_4_bit_pkg.sv
// serial_add_4_bit_pkg: shared state type and default operand width for the serial adder
package serial_add_4_bit_pkg;
   localparam int WIDTH_DEF = 4;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/serial_add_4_bit_full_adder.sv
// full_adder_1bit: single-bit full adder used as the serial datapath core
module full_adder_1bit (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_add_4_bit.sv
// serial_add_4_bit: bit-serial x + y + cin, LSB first, one bit per clock
module serial_add_4_bit
   import serial_add_4_bit_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = $clog2(WIDTH);
   state_t           state, nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] xr, yr, acc, acc_nx;
   logic             carry, s, co, last;
   full_adder_1bit u_fa (.a(xr[cnt]), .b(yr[cnt]), .ci(carry), .s(s), .co(co));
   always_comb begin
      last   = cnt == CW'(WIDTH - 1);
      nxt    = (state == IDLE) ? (start ? RUN : IDLE) :
               (state == RUN)  ? (last ? DONE : RUN) : IDLE;
      busy   = state != IDLE;
      done   = state == DONE;
      acc_nx = acc;
      acc_nx[cnt] = s;
   end
   always_ff @(posedge clk)
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   // acc collects result bits privately; sum only changes when the last bit lands
   always_ff @(posedge clk)
      if (!rst_n) begin
         cnt   <= '0;
         carry <= 1'b0;
         acc   <= '0;
         xr    <= '0;
         yr    <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else if (state == IDLE && start) begin
         xr    <= x;
         yr    <= y;
         carry <= cin;
         cnt   <= '0;
      end else if (state == RUN) begin
         acc   <= acc_nx;
         carry <= co;
         cnt   <= cnt + CW'(1);
         if (last) begin
            sum  <= acc_nx;
            cout <= co;
         end
      end
endmodule

// File: tb/tb_serial_add_4_bit.sv
// tb_serial_add_4_bit: scoreboard bench for the serial adder (directed cases, reset abort, exhaustive back-to-back)
module tb_serial_add_4_bit;
   localparam int W = 4;
   logic         clk = 0, rst_n = 0, start = 0, cin = 0;
   logic [W-1:0] x = '0, y = '0;
   logic         busy, done, cout;
   logic [W-1:0] sum;
   int           checks = 0, errors = 0, cyc = 0, dones = 0, done_cyc = 0, e0 = 0;
   logic [W:0]   sb[$];

   serial_add_4_bit #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk)
      if (done === 1'b1) begin
         dones++;
         done_cyc = cyc;
         chk("sb_depth", 32'(sb.size()), 1);
         if (sb.size() > 0) chk("result", 32'({cout, sum}), 32'(sb.pop_front()));
      end

   task automatic go(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      @(negedge clk);
      x = a; y = b; cin = c; start = 1;
      sb.push_back((W+1)'(a) + (W+1)'(b) + (W+1)'(c));
      @(negedge clk);
      start = 0;
      e0 = cyc;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (done !== 1'b1 && n < 20);
      chk({tag, "_done_seen"}, 32'(done), 1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int n, d0, prev;
      logic [3:0] xa, ya;
      logic ca;
      idle(2);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_sum", 32'(sum), 0);
      chk("rst_cout", 32'(cout), 0);
      rst_n = 1;
      idle(1);

      d0 = dones;
      go(4'd0, 4'd0, 1'b0);
      n = 0;
      while (busy === 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("busy_cycles", 32'(n), 5);
      chk("latency", 32'(done_cyc - e0), W);
      chk("zero_one_done", 32'(dones - d0), 1);

      go(4'd15, 4'd1, 1'b0); wait_done("c15_1");
      go(4'd7, 4'd8, 1'b1);  wait_done("c7_8_1");
      go(4'd5, 4'd3, 1'b0);  wait_done("c5_3");
      idle(4);
      chk("hold_result", 32'({cout, sum}), 32'(5'b01000));

      d0 = dones;
      go(4'd2, 4'd3, 1'b0);
      @(negedge clk);
      x = 4'd15; y = 4'd15; start = 1;
      wait_done("mid_change");
      start = 0;
      idle(10);
      chk("mid_change_one_done", 32'(dones - d0), 1);

      d0 = dones;
      @(negedge clk);
      x = 4'd9; y = 4'd9; cin = 0; start = 1;
      @(negedge clk);
      start = 0;
      @(negedge clk);
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      idle(8);
      chk("abort_no_done", 32'(dones - d0), 0);
      chk("abort_sum", 32'(sum), 0);
      chk("abort_cout", 32'(cout), 0);
      chk("abort_idle", 32'(busy), 0);
      go(4'd9, 4'd9, 1'b0);
      idle(2);
      chk("mid_run_sum", 32'(sum), 0);
      wait_done("restart");

      @(negedge clk);
      rst_n = 0; start = 1;
      @(negedge clk);
      rst_n = 1; start = 0;
      @(negedge clk);
      chk("rst_beats_start", 32'(busy), 0);

      @(negedge clk);
      prev = -1;
      for (int i = 0; i < 512; i++) begin
         {xa, ya, ca} = 9'(i);
         x = xa; y = ya; cin = ca; start = 1;
         sb.push_back(5'(xa) + 5'(ya) + 5'(ca));
         wait_done("exh");
         if (prev >= 0) chk("b2b_gap", 32'(done_cyc - prev), W + 2);
         prev = done_cyc;
      end
      start = 0;
      idle(10);
      chk("sb_drained", 32'(sb.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
